// File: rtl/in_stream_arbiter.sv
// Two-requester byte-stream arbiter in front of the usb_cdc IN bulk endpoint.
// Grants are held for a burst of MAX_PACKET bytes or until the owner goes quiet.
module in_stream_arbiter #(
  parameter int unsigned MAX_PACKET   = 8,
  parameter int unsigned IDLE_TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rstn_i,

  input  logic [7:0] req0_data_i,
  input  logic       req0_valid_i,
  output logic       req0_ready_o,

  input  logic [7:0] req1_data_i,
  input  logic       req1_valid_i,
  output logic       req1_ready_o,

  output logic [7:0] in_data_o,
  output logic       in_valid_o,
  input  logic       in_ready_i,

  output logic [1:0] grant_o
);

  localparam int unsigned CntW = $clog2(MAX_PACKET + 1);
  localparam logic [CntW-1:0] LastByte = CntW'(MAX_PACKET - 1);
  localparam logic [7:0]      IdleLast = 8'(IDLE_TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic [CntW-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]      idle_cnt_q, idle_cnt_d;

  logic granted;
  logic sel_valid;
  logic handshake;

  // Datapath is a pure mux so the granted stream sees no added latency.
  always_comb begin
    granted      = (state_q == StGrant);
    sel_valid    = owner_q ? req1_valid_i : req0_valid_i;
    in_valid_o   = granted & sel_valid;
    in_data_o    = granted ? (owner_q ? req1_data_i : req0_data_i) : 8'h00;
    req0_ready_o = granted & ~owner_q & in_ready_i;
    req1_ready_o = granted & owner_q & in_ready_i;
    grant_o      = granted ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    handshake    = in_valid_o & in_ready_i;
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    byte_cnt_d = byte_cnt_q;
    idle_cnt_d = idle_cnt_q;

    case (state_q)
      StIdle: begin
        byte_cnt_d = '0;
        idle_cnt_d = '0;
        if (req0_valid_i || req1_valid_i) begin
          state_d = StGrant;
          // On a tie the requester that was not served last wins.
          owner_d = (req0_valid_i && req1_valid_i) ? ~last_q : req1_valid_i;
        end
      end

      StGrant: begin
        // A handshake needs valid high, so it always outranks the idle timeout.
        if (handshake) begin
          idle_cnt_d = '0;
          if (byte_cnt_q == LastByte) begin
            state_d    = StIdle;
            byte_cnt_d = '0;
            last_d     = owner_q;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end else if (!sel_valid) begin
          if (idle_cnt_q == IdleLast) begin
            state_d    = StIdle;
            byte_cnt_d = '0;
            idle_cnt_d = '0;
            last_d     = owner_q;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d    = StIdle;
        byte_cnt_d = '0;
        idle_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      byte_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      byte_cnt_q <= byte_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

endmodule

// File: tb/tb_in_stream_arbiter.sv
// Self-checking bench for in_stream_arbiter: directed scenarios plus a randomized
// run scored against a burst-level reference model.
module tb_in_stream_arbiter;

  localparam int MaxPacket   = 8;
  localparam int IdleTimeout = 16;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] req0_data, req1_data, in_data;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic       in_valid, in_ready;
  logic [1:0] grant;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] src0[$], src1[$], out_q[$];
  logic [1:0] glog[$];
  bit         en0, en1, rdy;

  // Values observed in the most recent cycle.
  logic [1:0] cg;
  logic [7:0] cd;
  logic       cv, c_r0, c_r1, cin0, cin1, crdy, chs;

  in_stream_arbiter #(
    .MAX_PACKET  (MaxPacket),
    .IDLE_TIMEOUT(IdleTimeout)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .req0_data_i (req0_data),
    .req0_valid_i(req0_valid),
    .req0_ready_o(req0_ready),
    .req1_data_i (req1_data),
    .req1_valid_i(req1_valid),
    .req1_ready_o(req1_ready),
    .in_data_o   (in_data),
    .in_valid_o  (in_valid),
    .in_ready_i  (in_ready),
    .grant_o     (grant)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Drive from the source queues at posedge+1, observe at negedge, consume on handshake.
  task automatic run_cycle();
    req0_valid = en0 && (src0.size() > 0);
    req0_data  = (src0.size() > 0) ? src0[0] : 8'h00;
    req1_valid = en1 && (src1.size() > 0);
    req1_data  = (src1.size() > 0) ? src1[0] : 8'h00;
    in_ready   = rdy;
    @(negedge clk);
    cg   = grant;
    cv   = in_valid;
    cd   = in_data;
    c_r0 = req0_ready;
    c_r1 = req1_ready;
    cin0 = req0_valid;
    cin1 = req1_valid;
    crdy = in_ready;
    chs  = in_valid & in_ready;
    glog.push_back(cg);
    if (cin0 && c_r0) void'(src0.pop_front());
    if (cin1 && c_r1) void'(src1.pop_front());
    if (chs) out_q.push_back(cd);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    en0 = 1'b0; en1 = 1'b0; rdy = 1'b0;
    src0.delete(); src1.delete(); out_q.delete(); glog.delete();
    req0_valid = 1'b0; req1_valid = 1'b0; in_ready = 1'b0;
    req0_data = 8'h00; req1_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; in_ready = 1'b1;
    req0_data = 8'hAA; req1_data = 8'h55;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if ({grant, in_valid, req0_ready, req1_ready} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: got grant=%b valid=%b r0=%b r1=%b want all 0",
                 grant, in_valid, req0_ready, req1_ready);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    logic [1:0] want_g [5];
    int         idx    [5];
    do_reset();
    for (int i = 1; i <= 7; i++) src0.push_back(8'(i));
    en0 = 1'b1; rdy = 1'b1;
    repeat (26) run_cycle();
    idx = '{0, 1, 7, 23, 24};
    want_g = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (glog[idx[k]] !== want_g[k]) begin
        n_fail++;
        $display("FAIL single_grant[%0d]: got %b want %b", idx[k], glog[idx[k]], want_g[k]);
      end
    end
    n_tests++;
    if (out_q.size() != 7) begin
      n_fail++;
      $display("FAIL single_count: got %0d bytes want 7", out_q.size());
    end
    for (int i = 0; i < 7 && i < out_q.size(); i++) begin
      n_tests++;
      if (out_q[i] !== 8'(i + 1)) begin
        n_fail++;
        $display("FAIL single_data[%0d]: got %h want %h", i, out_q[i], 8'(i + 1));
      end
    end
  endtask

  task automatic test_tie();
    logic [7:0] exp[$];
    logic [1:0] want_g [7];
    int         idx    [7];
    do_reset();
    for (int i = 0; i < 16; i++) begin
      src0.push_back(8'(8'h10 + i));
      src1.push_back(8'(8'h20 + i));
    end
    for (int i = 0; i < 8; i++) exp.push_back(8'(8'h10 + i));
    for (int i = 0; i < 8; i++) exp.push_back(8'(8'h20 + i));
    for (int i = 0; i < 8; i++) exp.push_back(8'(8'h18 + i));
    for (int i = 0; i < 8; i++) exp.push_back(8'(8'h28 + i));
    en0 = 1'b1; en1 = 1'b1; rdy = 1'b1;
    repeat (40) run_cycle();
    idx = '{1, 9, 10, 18, 19, 27, 28};
    want_g = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    for (int k = 0; k < 7; k++) begin
      n_tests++;
      if (glog[idx[k]] !== want_g[k]) begin
        n_fail++;
        $display("FAIL tie_grant[%0d]: got %b want %b", idx[k], glog[idx[k]], want_g[k]);
      end
    end
    n_tests++;
    if (out_q.size() != exp.size()) begin
      n_fail++;
      $display("FAIL tie_count: got %0d bytes want %0d", out_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < out_q.size(); i++) begin
      n_tests++;
      if (out_q[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL tie_data[%0d]: got %h want %h", i, out_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 8; i++) src0.push_back(8'(8'h30 + i));
    en0 = 1'b1;
    for (int i = 0; i < 24; i++) begin
      rdy = i[0];
      run_cycle();
      if (cg == 2'b01) begin
        n_tests++;
        if (c_r0 !== crdy || c_r1 !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_ready[%0d]: got r0=%b r1=%b want r0=%b r1=0", i, c_r0, c_r1, crdy);
        end
      end
    end
    n_tests++;
    if (glog[15] !== 2'b01 || glog[16] !== 2'b00) begin
      n_fail++;
      $display("FAIL bp_release: got %b,%b want 01,00", glog[15], glog[16]);
    end
    n_tests++;
    if (out_q.size() != 8) begin
      n_fail++;
      $display("FAIL bp_count: got %0d handshakes want 8", out_q.size());
    end
    for (int i = 0; i < 8 && i < out_q.size(); i++) begin
      n_tests++;
      if (out_q[i] !== 8'(8'h30 + i)) begin
        n_fail++;
        $display("FAIL bp_data[%0d]: got %h want %h", i, out_q[i], 8'(8'h30 + i));
      end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] exp [5];
    logic [1:0] want_g [4];
    int         idx    [4];
    do_reset();
    src1 = '{8'h41, 8'h42, 8'h43};
    src0 = '{8'h51, 8'h52};
    en1 = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == 2) en0 = 1'b1;
      run_cycle();
      if (i >= 2 && i <= 19) begin
        n_tests++;
        if (c_r0 !== 1'b0) begin
          n_fail++;
          $display("FAIL to_no_preempt[%0d]: got r0=%b want 0", i, c_r0);
        end
      end
    end
    idx = '{1, 19, 20, 21};
    want_g = '{2'b10, 2'b10, 2'b00, 2'b01};
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (glog[idx[k]] !== want_g[k]) begin
        n_fail++;
        $display("FAIL to_grant[%0d]: got %b want %b", idx[k], glog[idx[k]], want_g[k]);
      end
    end
    exp = '{8'h41, 8'h42, 8'h43, 8'h51, 8'h52};
    n_tests++;
    if (out_q.size() != 5) begin
      n_fail++;
      $display("FAIL to_count: got %0d bytes want 5", out_q.size());
    end
    for (int i = 0; i < 5 && i < out_q.size(); i++) begin
      n_tests++;
      if (out_q[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL to_data[%0d]: got %h want %h", i, out_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] want_g [4];
    int         idx    [4];
    logic [7:0] w;
    do_reset();
    for (int i = 0; i < 8; i++) src0.push_back(8'(8'h60 + i));
    src1.push_back(8'h70);
    en1 = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      // Owner goes quiet for IdleTimeout-1 cycles, then sends the last byte.
      en0 = !(i >= 8 && i <= 8 + IdleTimeout - 2);
      run_cycle();
    end
    idx = '{22, 23, 24, 25};
    want_g = '{2'b01, 2'b01, 2'b00, 2'b10};
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (glog[idx[k]] !== want_g[k]) begin
        n_fail++;
        $display("FAIL sim_grant[%0d]: got %b want %b", idx[k], glog[idx[k]], want_g[k]);
      end
    end
    n_tests++;
    if (out_q.size() != 9) begin
      n_fail++;
      $display("FAIL sim_count: got %0d bytes want 9", out_q.size());
    end
    for (int i = 0; i < 9 && i < out_q.size(); i++) begin
      w = (i < 8) ? 8'(8'h60 + i) : 8'h70;
      n_tests++;
      if (out_q[i] !== w) begin
        n_fail++;
        $display("FAIL sim_data[%0d]: got %h want %h", i, out_q[i], w);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 8; i++) src0.push_back(8'(8'h80 + i));
    en0 = 1'b1; rdy = 1'b1;
    repeat (5) run_cycle();
    req0_valid = 1'b1; req0_data = src0[0]; in_ready = 1'b1;
    #1;
    n_tests++;
    if (grant !== 2'b01 || in_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rm_pre: got grant=%b valid=%b want 01,1", grant, in_valid);
    end
    #1 rstn = 1'b0;
    #1;
    n_tests++;
    if ({grant, in_valid, req0_ready, req1_ready} !== 5'b0) begin
      n_fail++;
      $display("FAIL rm_async: got grant=%b valid=%b r0=%b want all 0", grant, in_valid, req0_ready);
    end
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({grant, in_valid, req0_ready} !== 4'b0) begin
      n_fail++;
      $display("FAIL rm_hold: got grant=%b valid=%b r0=%b want all 0", grant, in_valid, req0_ready);
    end
    src0.delete(); out_q.delete(); glog.delete();
    for (int i = 0; i < 8; i++) src0.push_back(8'(8'h90 + i));
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (12) run_cycle();
    n_tests++;
    if (glog[0] !== 2'b00 || glog[1] !== 2'b01 || glog[8] !== 2'b01 || glog[9] !== 2'b00) begin
      n_fail++;
      $display("FAIL rm_burst: got %b,%b,%b,%b want 00,01,01,00", glog[0], glog[1], glog[8], glog[9]);
    end
    n_tests++;
    if (out_q.size() != 8) begin
      n_fail++;
      $display("FAIL rm_count: got %0d bytes want 8", out_q.size());
    end
    for (int i = 0; i < 8 && i < out_q.size(); i++) begin
      n_tests++;
      if (out_q[i] !== 8'(8'h90 + i)) begin
        n_fail++;
        $display("FAIL rm_data[%0d]: got %h want %h", i, out_q[i], 8'(8'h90 + i));
      end
    end
  endtask

  // Reference: owner (-1 none), bytes in current burst, consecutive quiet cycles.
  task automatic test_random();
    logic [7:0] exp0[$], exp1[$];
    logic [7:0] b, want_d;
    logic [1:0] want_g;
    logic       want_v, want_r0, want_r1, own_valid;
    int owner, last, burst, quiet;
    do_reset();
    owner = -1; last = 1; burst = 0; quiet = 0;
    en0 = 1'b1; en1 = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (src0.size() < 4 && $urandom_range(0, 1) == 1) begin
        b = 8'($urandom); src0.push_back(b); exp0.push_back(b);
      end
      if (src1.size() < 4 && $urandom_range(0, 1) == 1) begin
        b = 8'($urandom); src1.push_back(b); exp1.push_back(b);
      end
      if ($urandom_range(0, 24) == 0) en0 = !en0;
      if ($urandom_range(0, 24) == 0) en1 = !en1;
      rdy = ($urandom_range(0, 3) != 0);
      run_cycle();

      want_g  = (owner < 0) ? 2'b00 : ((owner == 0) ? 2'b01 : 2'b10);
      want_v  = (owner == 0) ? cin0 : ((owner == 1) ? cin1 : 1'b0);
      want_r0 = (owner == 0) ? crdy : 1'b0;
      want_r1 = (owner == 1) ? crdy : 1'b0;
      n_tests++;
      if ({cg, cv, c_r0, c_r1} !== {want_g, want_v, want_r0, want_r1}) begin
        n_fail++;
        $display("FAIL rnd_ctrl[%0d]: got g=%b v=%b r0=%b r1=%b want g=%b v=%b r0=%b r1=%b",
                 cyc, cg, cv, c_r0, c_r1, want_g, want_v, want_r0, want_r1);
      end
      if (chs && owner >= 0) begin
        want_d = 8'h00;
        if (owner == 0 && exp0.size() > 0) want_d = exp0.pop_front();
        if (owner == 1 && exp1.size() > 0) want_d = exp1.pop_front();
        n_tests++;
        if (cd !== want_d) begin
          n_fail++;
          $display("FAIL rnd_data[%0d]: got %h want %h", cyc, cd, want_d);
        end
      end

      if (owner < 0) begin
        if (cin0 && cin1) owner = (last == 0) ? 1 : 0;
        else if (cin0) owner = 0;
        else if (cin1) owner = 1;
        burst = 0; quiet = 0;
      end else begin
        own_valid = (owner == 0) ? cin0 : cin1;
        if (own_valid && crdy) begin
          burst++; quiet = 0;
          if (burst == MaxPacket) begin last = owner; owner = -1; end
        end else if (!own_valid) begin
          quiet++;
          if (quiet == IdleTimeout) begin last = owner; owner = -1; end
        end
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    en0 = 1'b0; en1 = 1'b0; rdy = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; in_ready = 1'b0;
    req0_data = 8'h00; req1_data = 8'h00;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_timeout();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/in_stream_arbiter.md
IN_STREAM_ARBITER -- requirements
Module: in_stream_arbiter

Interface
REQ-001 SHALL have parameter MAX_PACKET, default 8, meaning the burst length in bytes per grant (legal range 1..64).
REQ-002 SHALL have parameter IDLE_TIMEOUT, default 16, meaning the clk_i cycles without a granted byte before the grant is released (legal range 1..255).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 SHALL have port rstn_i, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have ports req0_data_i (input, 8 bits), req0_valid_i (input, 1), req0_ready_o (output, 1): byte stream of requester 0.
REQ-006 SHALL have ports req1_data_i (input, 8 bits), req1_valid_i (input, 1), req1_ready_o (output, 1): byte stream of requester 1.
REQ-007 SHALL have ports in_data_o (output, 8 bits), in_valid_o (output, 1), in_ready_i (input, 1): toward the usb_cdc IN bulk endpoint.
REQ-008 SHALL have port grant_o, output, 2 bits, one-hot owner of the IN endpoint (00 = none).

Function
REQ-009 SHALL be a two-state FSM: IDLE and GRANT.
REQ-010 In IDLE: in_valid_o = 0, req0_ready_o = req1_ready_o = 0, grant_o = 00.
REQ-011 In IDLE with exactly one reqN_valid_i high: GRANT to N on the next clk_i edge (1-cycle arbitration latency).
REQ-012 In IDLE with both valids high: grant the requester not served last (round-robin); after reset, requester 0 wins the first tie.
REQ-013 In GRANT to N, in_data_o / in_valid_o SHALL combinationally equal reqN_data_i / reqN_valid_i.
REQ-014 In GRANT to N, reqN_ready_o = in_ready_i; the other ready output SHALL be 0.
REQ-015 A handshake is in_valid_o & in_ready_i in one cycle; each handshake increments the byte counter (width clog2(MAX_PACKET+1)).
REQ-016 On the handshake that brings the count to MAX_PACKET: return to IDLE, clear the counter, and record N as last served.
REQ-017 In GRANT, each cycle with granted valid low increments the idle counter (8 bits); any handshake clears it.
REQ-018 When the idle counter reaches IDLE_TIMEOUT: return to IDLE, clear both counters, and record N as last served; a partial burst is legal.
REQ-019 If the final-byte handshake and the timeout fall in the same cycle, the handshake SHALL take precedence (the byte is transferred once, then IDLE).
REQ-020 While the grant is held, valid from the non-granted requester SHALL be ignored (no preemption).
REQ-021 Returning to IDLE SHALL cost exactly one dead cycle before any new grant (no back-to-back re-grant within the same cycle).
REQ-022 No byte SHALL be dropped or duplicated; stream order per requester SHALL be preserved.

Reset
REQ-023 While rstn_i = 0: state = IDLE, both counters = 0, last-served = 1 (so requester 0 wins the first tie), grant_o = 00, all ready/valid outputs = 0.
REQ-024 Reset asserted mid-burst SHALL abort the burst immediately and asynchronously; no handshake completes in that cycle.
REQ-025 After rstn_i deasserts, the FSM SHALL resume from IDLE on the first clk_i edge.

Verification
REQ-026 Single source: req0 sends 0x01..0x07, in_ready_i = 1 -> grant_o = 01 one cycle after valid, 7 bytes in order, IDLE after 16 idle cycles.
REQ-027 Tie: both valid at once after reset, 16 bytes each (0x1n / 0x2n), MAX_PACKET = 8 -> output 0x10..0x17, 0x20..0x27, 0x18..0x1F, 0x28..0x2F, with one dead cycle between bursts.
REQ-028 Backpressure: in_ready_i toggles every cycle during an 8-byte burst -> exactly 8 handshakes, no duplicates, req0_ready_o mirrors in_ready_i.
REQ-029 Timeout: req1 sends 3 bytes then drops valid while req0 waits -> req1 released after IDLE_TIMEOUT cycles, then grant_o = 01.
REQ-030 Simultaneous events: 8th handshake coincides with the timeout -> byte counted once, return to IDLE, next grant goes to the other requester.
REQ-031 Reset mid-burst after 4 bytes -> outputs 0 immediately; after release, a fresh 8-byte burst completes from count 0.
